// File: rtl/vga640_pkg.sv
// Shared VGA 640x480 geometry for the capture and display paths.
// Both ends import this package so the window position and size always match.
package vga640_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_WIN_X0 = 270;
    localparam int VGA_WIN_Y0 = 190;
    localparam int VGA_WIN_W  = 100;
    localparam int VGA_WIN_H  = 100;

    localparam int PIX_W  = 3;
    localparam int ADDR_W = 16;

    typedef logic [PIX_W-1:0] pixel_t;

    // Per-pixel attributes that travel alongside the RAM read latency.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic in_win;
        logic border;
        logic first;
    } flags_t;

    localparam flags_t FLAGS_IDLE = '{hsync: 1'b1, vsync: 1'b1, in_win: 1'b0,
                                      border: 1'b0, first: 1'b0};

    function automatic logic in_span(input int val, input int lo, input int hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters for the VGA scan: pixel/line counters, active-low syncs,
// the active-area flag and a marker for the first pixel of each frame.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          sysclk,
    input  logic          reset,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          frame_first
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    always_comb begin
        hsync       = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
        vsync       = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
        active      = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
        frame_first = (hcnt == '0) && (vcnt == '0);
    end

endmodule

// File: rtl/ram2vga.sv
// Frame-buffer reader: scans the VGA raster, reads the captured window out of
// the frame RAM and shows it framed by an optional white border.
module ram2vga
    import vga640_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int WIN_X0    = VGA_WIN_X0,
    parameter int WIN_Y0    = VGA_WIN_Y0,
    parameter int WIN_W     = VGA_WIN_W,
    parameter int WIN_H     = VGA_WIN_H,
    parameter int BORDER_EN = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [PIX_W-1:0]  rddata,
    output logic [ADDR_W-1:0] rdaddr,
    output logic              rdclock,
    output logic              rden,
    output logic              vga_r,
    output logic              vga_g,
    output logic              vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          frame_first;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .sysclk      (sysclk),
        .reset       (reset),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .frame_first (frame_first)
    );

    int     x;
    int     y;
    logic   in_win;
    logic   ring;
    logic   border;
    flags_t stage0;

    // Border is the one-pixel ring just outside the window, corners included.
    always_comb begin
        x      = int'(hcnt);
        y      = int'(vcnt);
        in_win = active
                 && in_span(x, WIN_X0, WIN_X0 + WIN_W - 1)
                 && in_span(y, WIN_Y0, WIN_Y0 + WIN_H - 1);
        ring   = ((x == WIN_X0 - 1 || x == WIN_X0 + WIN_W)
                   && in_span(y, WIN_Y0 - 1, WIN_Y0 + WIN_H))
                 || ((y == WIN_Y0 - 1 || y == WIN_Y0 + WIN_H)
                   && in_span(x, WIN_X0 - 1, WIN_X0 + WIN_W));
        border = active && ring && (BORDER_EN != 0);
        stage0 = '{hsync: hsync, vsync: vsync, in_win: in_win,
                   border: border, first: frame_first};
    end

    // One spare bit so a full 65536-pixel window can rest past its last address.
    logic [ADDR_W:0] addr;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            addr   <= '0;
            rdaddr <= '0;
            rden   <= 1'b0;
        end else begin
            rden <= in_win;
            if (in_win) begin
                rdaddr <= frame_first ? '0 : addr[ADDR_W-1:0];
            end
            if (frame_first) begin
                addr <= {{ADDR_W{1'b0}}, in_win};
            end else if (in_win) begin
                addr <= addr + 1'b1;
            end
        end
    end

    flags_t d1;
    flags_t d2;
    pixel_t colour;

    // d1/d2 cover the address register and the RAM's own read register.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            d1          <= FLAGS_IDLE;
            d2          <= FLAGS_IDLE;
            colour      <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            d1          <= stage0;
            d2          <= d1;
            colour      <= d2.in_win ? rddata : (d2.border ? '1 : '0);
            vga_hs      <= d2.hsync;
            vga_vs      <= d2.vsync;
            frame_start <= d2.first;
        end
    end

    assign {vga_r, vga_g, vga_b} = colour;
    assign rdclock = sysclk;

endmodule

// File: tb/tb_ram2vga.sv
// Bench for ram2vga on a scaled-down raster so full frames fit in a short run;
// two instances differ only in BORDER_EN and share one frame-RAM image.
module tb_ram2vga;

    localparam int HA = 40, HF = 4, HS = 8, HB = 8;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int WX = 10, WY = 8, WW = 12, WH = 10;
    localparam int N = WW * WH;
    localparam int MID_RESET = (WY + 4) * HT + WX + 5;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [2:0]  rddata_b, rddata_n;
    logic [15:0] rdaddr_b, rdaddr_n;
    logic        rdclock_b, rdclock_n, rden_b, rden_n;
    logic        r_b, g_b, bl_b, hs_b, vs_b, fs_b;
    logic        r_n, g_n, bl_n, hs_n, vs_n, fs_n;

    logic [2:0]  mem [N];

    always #20 sysclk = ~sysclk;

    ram2vga #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .WIN_X0(WX), .WIN_Y0(WY), .WIN_W(WW), .WIN_H(WH), .BORDER_EN(1)
    ) dut_b (
        .sysclk(sysclk), .reset(reset), .rddata(rddata_b), .rdaddr(rdaddr_b),
        .rdclock(rdclock_b), .rden(rden_b), .vga_r(r_b), .vga_g(g_b), .vga_b(bl_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .frame_start(fs_b)
    );

    ram2vga #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .WIN_X0(WX), .WIN_Y0(WY), .WIN_W(WW), .WIN_H(WH), .BORDER_EN(0)
    ) dut_n (
        .sysclk(sysclk), .reset(reset), .rddata(rddata_n), .rdaddr(rdaddr_n),
        .rdclock(rdclock_n), .rden(rden_n), .vga_r(r_n), .vga_g(g_n), .vga_b(bl_n),
        .vga_hs(hs_n), .vga_vs(vs_n), .frame_start(fs_n)
    );

    // Synchronous-read frame RAM: data for an address appears one cycle later.
    always @(posedge sysclk) begin
        rddata_b <= (int'(rdaddr_b) < N) ? mem[rdaddr_b] : 3'b000;
        rddata_n <= (int'(rdaddr_n) < N) ? mem[rdaddr_n] : 3'b000;
    end

    int tests = 0;
    int fails = 0;
    int e = 0;
    int exp_addr = 0;
    bit capture = 0;
    int cap_b [FRAME];
    int cap_n [FRAME];

    int fs_q [$];
    int burst_start [$];
    int burst_len [$];
    int hs_low, vs_low, first_hs_low, first_rden_e, max_rd, cur_len;
    logic prev_rden;

    typedef struct {
        int x;
        int y;
        int with_border;
        int no_border;
    } pix_vec_t;

    pix_vec_t vecs [$];

    // Reference model: position p counts pixels scanned since reset release.
    function automatic int m_h(int p); return p % HT; endfunction
    function automatic int m_v(int p); return (p / HT) % VT; endfunction

    function automatic bit m_in_win(int p);
        int h = m_h(p);
        int v = m_v(p);
        return h >= WX && h < WX + WW && v >= WY && v < WY + WH;
    endfunction

    function automatic int m_addr(int p);
        return (m_v(p) - WY) * WW + (m_h(p) - WX);
    endfunction

    function automatic bit m_border(int p);
        int h = m_h(p);
        int v = m_v(p);
        bit inside_outer = h >= WX - 1 && h <= WX + WW && v >= WY - 1 && v <= WY + WH;
        return inside_outer && !m_in_win(p);
    endfunction

    function automatic int m_colour(int p, bit border_en);
        if (p < 0) return 0;
        if (m_in_win(p)) return int'(mem[m_addr(p)]);
        if (border_en && m_border(p)) return 7;
        return 0;
    endfunction

    function automatic int m_hs(int p);
        int h;
        if (p < 0) return 1;
        h = m_h(p);
        return (h >= HA + HF && h < HA + HF + HS) ? 0 : 1;
    endfunction

    function automatic int m_vs(int p);
        int v;
        if (p < 0) return 1;
        v = m_v(p);
        return (v >= VA + VF && v < VA + VF + VS) ? 0 : 1;
    endfunction

    function automatic int m_fs(int p);
        return (p >= 0 && p % FRAME == 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            if (fails <= 25)
                $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d",
                         name, e, actual, expected);
        end
    endtask

    task automatic clearStats();
        fs_q.delete();
        burst_start.delete();
        burst_len.delete();
        hs_low = 0;
        vs_low = 0;
        first_hs_low = -1;
        first_rden_e = -1;
        max_rd = -1;
        cur_len = 0;
        prev_rden = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_colour_b"}, int'({r_b, g_b, bl_b}), 0);
        check({tag, "_colour_n"}, int'({r_n, g_n, bl_n}), 0);
        check({tag, "_hs"}, int'(hs_b), 1);
        check({tag, "_vs"}, int'(vs_b), 1);
        check({tag, "_fs"}, int'(fs_b), 0);
        check({tag, "_rden"}, int'(rden_b), 0);
        check({tag, "_rdaddr"}, int'(rdaddr_b), 0);
        check({tag, "_rdaddr_n"}, int'(rdaddr_n), 0);
    endtask

    task automatic checkOutput();
        int p = e - 3;
        int p1 = e - 1;
        bit exp_rden = (p1 >= 0) && m_in_win(p1);
        if (exp_rden) exp_addr = m_addr(p1);
        check("colour_b", int'({r_b, g_b, bl_b}), m_colour(p, 1'b1));
        check("colour_n", int'({r_n, g_n, bl_n}), m_colour(p, 1'b0));
        check("hs", int'(hs_b), m_hs(p));
        check("vs", int'(vs_b), m_vs(p));
        check("frame_start", int'(fs_b), m_fs(p));
        check("hs_n", int'(hs_n), m_hs(p));
        check("vs_n", int'(vs_n), m_vs(p));
        check("frame_start_n", int'(fs_n), m_fs(p));
        check("rden", int'(rden_b), int'(exp_rden));
        check("rdaddr", int'(rdaddr_b), exp_addr);
        check("rden_n", int'(rden_n), int'(exp_rden));
        check("rdaddr_n", int'(rdaddr_n), exp_addr);
    endtask

    task automatic collect();
        if (fs_b) fs_q.push_back(e);
        if (e >= 3 && e < 3 + FRAME) begin
            if (!hs_b) begin
                hs_low++;
                if (first_hs_low < 0) first_hs_low = e;
            end
            if (!vs_b) vs_low++;
            if (capture) begin
                cap_b[e - 3] = int'({r_b, g_b, bl_b});
                cap_n[e - 3] = int'({r_n, g_n, bl_n});
            end
        end
        if (rden_b) begin
            if (!prev_rden) begin
                burst_start.push_back(int'(rdaddr_b));
                cur_len = 0;
                if (first_rden_e < 0) first_rden_e = e;
            end
            cur_len++;
            if (int'(rdaddr_b) > max_rd) max_rd = int'(rdaddr_b);
        end else if (prev_rden) begin
            burst_len.push_back(cur_len);
        end
        prev_rden = rden_b;
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            e++;
            @(negedge sysclk);
            checkOutput();
            collect();
        end
    endtask

    task automatic checkBursts(input string tag, input int expected_count);
        check({tag, "_burst_count"}, burst_start.size(), expected_count);
        check({tag, "_burst_ends"}, burst_len.size(), expected_count);
        for (int i = 0; i < burst_start.size(); i++)
            check({tag, "_burst_start"}, burst_start[i], (i % WH) * WW);
        for (int i = 0; i < burst_len.size(); i++)
            check({tag, "_burst_len"}, burst_len[i], WW);
        check({tag, "_max_rdaddr"}, max_rd, N - 1);
        check({tag, "_first_rden"}, first_rden_e, WY * HT + WX + 1);
    endtask

    initial begin
        // Pixel samples with RAM content = address[2:0]: {x, y, border on, border off}.
        vecs.push_back('{10,  8, 0, 0});
        vecs.push_back('{11,  8, 1, 1});
        vecs.push_back('{17,  8, 7, 7});
        vecs.push_back('{ 9,  8, 7, 0});
        vecs.push_back('{ 8,  8, 0, 0});
        vecs.push_back('{10,  9, 4, 4});
        vecs.push_back('{16, 12, 6, 6});
        vecs.push_back('{21, 17, 7, 7});
        vecs.push_back('{22, 17, 7, 0});
        vecs.push_back('{15,  7, 7, 0});
        vecs.push_back('{15, 18, 7, 0});
        vecs.push_back('{ 9,  7, 7, 0});
        vecs.push_back('{22, 18, 7, 0});
        vecs.push_back('{23, 18, 0, 0});
        vecs.push_back('{ 0,  0, 0, 0});
        vecs.push_back('{15, 25, 0, 0});
        vecs.push_back('{50,  5, 0, 0});

        for (int i = 0; i < N; i++) mem[i] = 3'(i);
        reset = 1'b1;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        checkReset("init");

        reset = 1'b0;
        e = 0;
        exp_addr = 0;
        clearStats();
        capture = 1'b1;
        applyStimulus(2 * FRAME + 10);
        capture = 1'b0;

        check("fs_count", fs_q.size(), 3);
        if (fs_q.size() > 0) check("fs_first", fs_q[0], 3);
        for (int i = 1; i < fs_q.size(); i++)
            check("fs_period", fs_q[i] - fs_q[i-1], FRAME);
        check("hs_low_cycles", hs_low, HS * VT);
        check("vs_low_cycles", vs_low, VS * HT);
        check("hs_first_low", first_hs_low, 3 + HA + HF);
        checkBursts("freerun", 2 * WH);

        for (int i = 0; i < vecs.size(); i++) begin
            check("pixel_border_on", cap_b[vecs[i].y * HT + vecs[i].x], vecs[i].with_border);
            check("pixel_border_off", cap_n[vecs[i].y * HT + vecs[i].x], vecs[i].no_border);
        end

        // Fresh random image, then a reset landing in the middle of the window.
        reset = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = 3'($urandom_range(7, 0));
        #1;
        checkReset("reassert");
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        e = 0;
        exp_addr = 0;
        clearStats();
        applyStimulus(MID_RESET);

        reset = 1'b1;
        #1;
        checkReset("mid_window");
        @(negedge sysclk);
        reset = 1'b0;
        e = 0;
        exp_addr = 0;
        clearStats();
        applyStimulus(FRAME + 20);
        check("restart_fs_first", (fs_q.size() > 0) ? fs_q[0] : -1, 3);
        checkBursts("restart", WH);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
